key_filter: RTL and testbench

- Debounces the raw mechanical push-button input.
- Delivers a clean level plus single-cycle press/release pulses to downstream logic (LED toggles, mode select, counters) in place of the raw key level.
- Sits between the board key pin and any consumer. It is the receiving end of the physical key interface, with synchronizer, stability counter and press/release FSM.

---
 rtl/key_filter.sv | 143 ++++++++++++++
 tb/tb_key_filter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// key_filter: push-button debouncer.
//
// Turns a raw, bouncing, asynchronous key level into a clean debounced level
// plus single-cycle press/release pulses for downstream logic.
//
// Ports:
//   sys_clk          in   system clock, all logic on the rising edge
//   sys_rest_n       in   synchronous active-low reset
//   key_in           in   raw asynchronous key level (bouncing)
//   key_flag         out  one-cycle pulse on a debounced press
//   key_release_flag out  one-cycle pulse on a debounced release
//   key_state        out  debounced level, 1 = pressed, 0 = released
//
// There is no handshake: key_flag / key_release_flag are fire-and-forget
// pulses, valid for exactly the one cycle they are high, with no ready/back-
// pressure. key_state is a level that is valid every cycle.
//
// A new level is accepted only after CNT_MAX consecutive synchronized cycles
// of that level; any single cycle of the old level restarts filtering.
// The FSM state is kept in state_q (typed enum) for checkers to bind to.

module key_filter #(
    parameter logic [19:0] CNT_MAX    = 20'd999_999,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rest_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_release_flag,
    output logic key_state
);

    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    // Last count value of a filter run; reaching it with the new level still
    // present completes the CNT_MAX-cycle qualification.
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 20'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_FILT = 2'd1,
        DOWN   = 2'd2,
        R_FILT = 2'd3
    } state_t;

    // Two-flop synchronizer for the asynchronous key pin.
    logic    sync1_q, sync2_q;

    state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic    key_state_q, key_state_d;
    logic    key_flag_q, key_flag_d;
    logic    key_rel_q, key_rel_d;
    logic    act;

    assign act = (sync2_q == KEY_ACTIVE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rest_n) begin
            sync1_q     <= ~KEY_ACTIVE;
            sync2_q     <= ~KEY_ACTIVE;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            key_flag_q  <= 1'b0;
            key_rel_q   <= 1'b0;
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            key_flag_q  <= key_flag_d;
            key_rel_q   <= key_rel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        key_flag_d  = 1'b0;
        key_rel_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = P_FILT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end

            P_FILT: begin
                if (!act) begin
                    // Bounce back to released: discard the partial run.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DOWN;
                    cnt_d       = '0;
                    key_state_d = 1'b1;
                    key_flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DOWN: begin
                if (!act) begin
                    state_d = R_FILT;
                    cnt_d   = CW'(1);
                end
            end

            R_FILT: begin
                if (act) begin
                    // Release bounce: still pressed.
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    key_state_d = 1'b0;
                    key_rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_flag         = key_flag_q;
    assign key_release_flag = key_rel_q;
    assign key_state        = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
// Testbench for key_filter (CNT_MAX = 4, KEY_ACTIVE = 0, 20 ns clock).
// The reference model tracks the debounced level as "a new level must be seen
// CNT_MAX times in a row at the synchronizer output", using a run length.

module tb_key_filter;

    localparam logic [19:0] CNT_MAX    = 20'd4;
    localparam logic        KEY_ACTIVE = 1'b0;

    logic sys_clk;
    logic sys_rest_n;
    logic key_in;
    logic key_flag;
    logic key_release_flag;
    logic key_state;

    key_filter #(
        .CNT_MAX   (CNT_MAX),
        .KEY_ACTIVE(KEY_ACTIVE)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rest_n      (sys_rest_n),
        .key_in          (key_in),
        .key_flag        (key_flag),
        .key_release_flag(key_release_flag),
        .key_state       (key_state)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // ---------------- scoreboard state ----------------
    logic [2:0] exp_q[$];   // {key_flag, key_release_flag, key_state}
    int checks = 0;
    int passed = 0;
    int flag_cnt = 0;
    int rel_cnt = 0;

    // ---------------- reference model ----------------
    logic m_s1 = ~KEY_ACTIVE;
    logic m_s2 = ~KEY_ACTIVE;
    logic m_pressed = 1'b0;
    int   m_run = 0;

    task automatic model_step(input logic k, input logic r);
        logic f, rf, a;
        f  = 1'b0;
        rf = 1'b0;
        if (!r) begin
            m_s1      = ~KEY_ACTIVE;
            m_s2      = ~KEY_ACTIVE;
            m_pressed = 1'b0;
            m_run     = 0;
        end else begin
            a = (m_s2 == KEY_ACTIVE);
            if (a != m_pressed) begin
                m_run++;
                if (m_run == int'(CNT_MAX)) begin
                    m_pressed = a;
                    f         = a;
                    rf        = !a;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = k;
        end
        exp_q.push_back({f, rf, m_pressed});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic k, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            key_in     = k;
            sys_rest_n = r;
            @(posedge sys_clk);
            #1;
            model_step(k, r);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic settle();
        @(negedge sys_clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        logic [2:0] e;
        if (key_flag === 1'b1) flag_cnt++;
        if (key_release_flag === 1'b1) rel_cnt++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({key_flag, key_release_flag, key_state} === e) passed++;
            else $display("FAIL cycle_out at %0t: got flag/rel/state=%b%b%b, expected %b%b%b",
                          $time, key_flag, key_release_flag, key_state, e[2], e[1], e[0]);
            checks++;
            if (!(key_flag === 1'b1 && key_release_flag === 1'b1)) passed++;
            else $display("FAIL both_pulses at %0t: got flag=1 rel=1, expected at most one", $time);
        end
    end

    // ---------------- stimulus ----------------
    int f0, r0;

    initial begin
        key_in     = 1'b1;
        sys_rest_n = 1'b0;
        @(negedge sys_clk);

        // 1. reset with key toggling
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1);
        settle();
        check_eq("reset_flags", flag_cnt + rel_cnt, 0);

        // 2. clean press
        drive(1'b1, 1'b1, 4);
        f0 = flag_cnt;
        drive(1'b0, 1'b1, 5);
        settle();
        check_eq("press_not_before_edge5", flag_cnt - f0, 0);
        drive(1'b0, 1'b1, 1);
        settle();
        check_eq("press_at_edge5", flag_cnt - f0, 1);
        check_eq("press_state", int'(key_state), 1);
        drive(1'b0, 1'b1, 14);
        settle();
        check_eq("press_single_flag", flag_cnt - f0, 1);

        // release back to idle before the bounce test
        drive(1'b1, 1'b1, 10);
        settle();
        check_eq("idle_before_bounce", int'(key_state), 0);

        // 3. press bounce
        f0 = flag_cnt;
        drive(1'b0, 1'b1, 3);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 2);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 5);
        settle();
        check_eq("bounce_no_early_flag", flag_cnt - f0, 0);
        drive(1'b0, 1'b1, 5);
        settle();
        check_eq("bounce_one_flag", flag_cnt - f0, 1);

        // 4. release bounce then real release
        r0 = rel_cnt;
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b1, 6);
        settle();
        check_eq("release_bounce_rejected", rel_cnt - r0, 0);
        check_eq("release_bounce_state", int'(key_state), 1);
        drive(1'b1, 1'b1, 10);
        settle();
        check_eq("release_one_pulse", rel_cnt - r0, 1);
        check_eq("release_state", int'(key_state), 0);

        // 5. reset mid-filter
        f0 = flag_cnt;
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 2);
        settle();
        check_eq("midreset_state", int'(key_state), 0);
        drive(1'b0, 1'b1, 5);
        settle();
        check_eq("midreset_no_early_flag", flag_cnt - f0, 0);
        drive(1'b0, 1'b1, 5);
        settle();
        check_eq("midreset_one_flag", flag_cnt - f0, 1);

        // 6. alternating input from idle
        drive(1'b1, 1'b1, 10);
        f0 = flag_cnt;
        r0 = rel_cnt;
        for (int i = 0; i < 100; i++) drive(i[0], 1'b1, 1);
        settle();
        check_eq("alt_no_flags", (flag_cnt - f0) + (rel_cnt - r0), 0);
        check_eq("alt_state", int'(key_state), 0);

        // randomized bouncing with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 49) != 0),
                  int'($urandom_range(1, 7)));
        end

        settle();
        check_eq("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Guard against a runaway simulation.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

endmodule
